// File: rtl/softmax_pkg.sv
// Shared types for the softmax sequencing controller: FSM state encoding and lane count.
package softmax_pkg;

  localparam int SM_LANES = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAX   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } sm_state_e;

endpackage

// File: rtl/softmax_sched_if.sv
// Bundle of the logit-input, datapath and result handshakes of softmax_sched.
// slave = the controller, master = the environment driving it.
interface softmax_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_x1, in_x2, in_x3, in_x4;
  logic                  sm_enable;
  logic [DATA_WIDTH-1:0] sm_in1, sm_in2, sm_in3, sm_in4;
  logic [DATA_WIDTH-1:0] sm_max;
  logic [DATA_WIDTH-1:0] sm_out1, sm_out2, sm_out3, sm_out4;
  logic                  sm_done;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_y1, res_y2, res_y3, res_y4;
  logic                  res_error;
  logic                  busy;

  modport slave (
    input  in_valid, in_x1, in_x2, in_x3, in_x4,
    input  sm_out1, sm_out2, sm_out3, sm_out4, sm_done, res_ready,
    output in_ready, sm_enable, sm_in1, sm_in2, sm_in3, sm_in4, sm_max,
    output res_valid, res_y1, res_y2, res_y3, res_y4, res_error, busy
  );

  modport master (
    output in_valid, in_x1, in_x2, in_x3, in_x4,
    output sm_out1, sm_out2, sm_out3, sm_out4, sm_done, res_ready,
    input  in_ready, sm_enable, sm_in1, sm_in2, sm_in3, sm_in4, sm_max,
    input  res_valid, res_y1, res_y2, res_y3, res_y4, res_error, busy
  );
endinterface

// File: rtl/softmax_max_seq.sv
// Iterative maximum register: load seeds it, each step folds in lane i_idx when strictly greater.
// ARITH_TYPE selects signed (1) or unsigned (0) comparison.
module softmax_max_seq
  import softmax_pkg::*;
#(
  parameter int ARITH_TYPE = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_load,
  input  logic [DATA_WIDTH-1:0]                i_load_val,
  input  logic                                 i_step,
  input  logic [$clog2(SM_LANES)-1:0]          i_idx,
  input  logic [SM_LANES-1:0][DATA_WIDTH-1:0]  i_vec,
  output logic [DATA_WIDTH-1:0]                o_max
);

  logic [DATA_WIDTH-1:0] r_max;
  logic [DATA_WIDTH-1:0] w_cand;
  logic                  w_gt;

  function automatic logic is_greater(input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] b);
    if (ARITH_TYPE != 0) begin
      return $signed(a) > $signed(b);
    end else begin
      return a > b;
    end
  endfunction

  assign w_cand = i_vec[i_idx];
  assign w_gt   = is_greater(w_cand, r_max);

  // Ties keep the earlier element, so only a strict win replaces the max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max <= '0;
    end else if (i_load) begin
      r_max <= i_load_val;
    end else if (i_step && w_gt) begin
      r_max <= w_cand;
    end
  end

  assign o_max = r_max;

endmodule

// File: rtl/softmax_sched.sv
// Sequencing controller for the 4-lane softmax datapath: IDLE -> MAX(3) -> START -> WAIT -> DONE.
// Optional WAIT watchdog compiled in with SOFTMAX_SCHED_WATCHDOG_EN.
module softmax_sched
  import softmax_pkg::*;
#(
  parameter int ARITH_TYPE     = 1,
  parameter int DATA_WIDTH     = 32,
  parameter int INTEGER        = 16,
  parameter int FRACTION       = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           reset,
  softmax_sched_if.slave bus
);

  localparam int IDX_W = $clog2(SM_LANES);

  sm_state_e                            r_state, w_state_nxt;
  logic [IDX_W-1:0]                     r_max_cnt;
  logic [SM_LANES-1:0][DATA_WIDTH-1:0]  r_sm_in;
  logic [SM_LANES-1:0][DATA_WIDTH-1:0]  r_res_y;
  logic [SM_LANES-1:0][DATA_WIDTH-1:0]  w_sm_out;
  logic [DATA_WIDTH-1:0]                w_max;
  logic                                 w_accept, w_capture, w_timeout;

  // Q-format and watchdog limit are datapath-facing only; an odd combination builds nothing.
  if ((INTEGER + FRACTION) != DATA_WIDTH || TIMEOUT_CYCLES < 1) begin : g_cfg_unusual
  end

  assign w_sm_out  = {bus.sm_out4, bus.sm_out3, bus.sm_out2, bus.sm_out1};
  assign w_accept  = (r_state == ST_IDLE) && bus.in_valid;
  assign w_capture = (r_state == ST_WAIT) && bus.sm_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.in_valid) w_state_nxt = ST_MAX; else w_state_nxt = ST_IDLE;
      ST_MAX:   if (r_max_cnt == IDX_W'(SM_LANES - 2)) w_state_nxt = ST_START;
                else w_state_nxt = ST_MAX;
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.sm_done || w_timeout) w_state_nxt = ST_DONE;
                else w_state_nxt = ST_WAIT;
      ST_DONE:  if (bus.res_ready) w_state_nxt = ST_IDLE; else w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Logits stay on sm_in until the next acceptance; results latched on done, zeroed on timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max_cnt <= '0;
      r_sm_in   <= '0;
      r_res_y   <= '0;
    end else begin
      if (w_accept) begin
        r_max_cnt <= '0;
        r_sm_in   <= {bus.in_x4, bus.in_x3, bus.in_x2, bus.in_x1};
      end else if (r_state == ST_MAX) begin
        r_max_cnt <= r_max_cnt + IDX_W'(1);
      end
      if (w_capture) begin
        r_res_y <= w_sm_out;
      end else if (w_timeout) begin
        r_res_y <= '0;
      end
    end
  end

  softmax_max_seq #(
    .ARITH_TYPE (ARITH_TYPE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_max_seq (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_load_val (bus.in_x1),
    .i_step     (r_state == ST_MAX),
    .i_idx      (r_max_cnt + IDX_W'(1)),
    .i_vec      (r_sm_in),
    .o_max      (w_max)
  );

`ifdef SOFTMAX_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_res_error;

  // Counts WAIT cycles; a done in the limit cycle takes priority over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt    <= '0;
      r_res_error <= 1'b0;
    end else begin
      if (r_state != ST_WAIT) r_wd_cnt <= '0;
      else                    r_wd_cnt <= r_wd_cnt + WD_W'(1);
      if (w_capture)      r_res_error <= 1'b0;
      else if (w_timeout) r_res_error <= 1'b1;
    end
  end

  assign w_timeout     = (r_state == ST_WAIT) && !bus.sm_done &&
                         (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign bus.res_error = r_res_error;
`else
  assign w_timeout     = 1'b0;
  assign bus.res_error = 1'b0;
`endif

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.sm_enable = (r_state == ST_START);
  assign bus.res_valid = (r_state == ST_DONE);
  assign bus.sm_max    = w_max;
  assign bus.sm_in1    = r_sm_in[0];
  assign bus.sm_in2    = r_sm_in[1];
  assign bus.sm_in3    = r_sm_in[2];
  assign bus.sm_in4    = r_sm_in[3];
  assign bus.res_y1    = r_res_y[0];
  assign bus.res_y2    = r_res_y[1];
  assign bus.res_y3    = r_res_y[2];
  assign bus.res_y4    = r_res_y[3];

endmodule

// File: tb/tb_softmax_sched.sv
// Self-checking bench for softmax_sched: a signed and an unsigned instance share one stimulus stream,
// expected values come from a plain fold-max reference and the cycle timeline of the controller.
module tb_softmax_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              in_valid, sm_done, res_ready;
  logic [3:0][31:0]  in_x, sm_out;
  int                n_checks = 0;
  int                n_fail   = 0;

  softmax_sched_if #(.DATA_WIDTH(32)) bus_s ();
  softmax_sched_if #(.DATA_WIDTH(32)) bus_u ();

  assign {bus_s.in_valid, bus_u.in_valid}   = {2{in_valid}};
  assign {bus_s.sm_done, bus_u.sm_done}     = {2{sm_done}};
  assign {bus_s.res_ready, bus_u.res_ready} = {2{res_ready}};
  assign {bus_s.in_x1, bus_s.in_x2, bus_s.in_x3, bus_s.in_x4} = {in_x[0], in_x[1], in_x[2], in_x[3]};
  assign {bus_u.in_x1, bus_u.in_x2, bus_u.in_x3, bus_u.in_x4} = {in_x[0], in_x[1], in_x[2], in_x[3]};
  assign {bus_s.sm_out1, bus_s.sm_out2, bus_s.sm_out3, bus_s.sm_out4} = {sm_out[0], sm_out[1], sm_out[2], sm_out[3]};
  assign {bus_u.sm_out1, bus_u.sm_out2, bus_u.sm_out3, bus_u.sm_out4} = {sm_out[0], sm_out[1], sm_out[2], sm_out[3]};

  softmax_sched #(.ARITH_TYPE(1), .DATA_WIDTH(32), .INTEGER(16), .FRACTION(16), .TIMEOUT_CYCLES(8))
    u_dut_s (.clk(clk), .reset(reset), .bus(bus_s));
  softmax_sched #(.ARITH_TYPE(0), .DATA_WIDTH(32), .INTEGER(16), .FRACTION(16), .TIMEOUT_CYCLES(8))
    u_dut_u (.clk(clk), .reset(reset), .bus(bus_u));

  logic [3:0][31:0] dut_sm_in, dut_res_y;
  assign dut_sm_in = {bus_s.sm_in4, bus_s.sm_in3, bus_s.sm_in2, bus_s.sm_in1};
  assign dut_res_y = {bus_s.res_y4, bus_s.res_y3, bus_s.res_y2, bus_s.res_y1};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_max(input logic [3:0][31:0] v, input bit is_signed);
    logic [31:0] best = v[0];
    for (int i = 1; i < 4; i++) begin
      if (is_signed ? ($signed(v[i]) > $signed(best)) : (v[i] > best)) best = v[i];
    end
    return best;
  endfunction

  function automatic logic [3:0][31:0] rand_vec();
    logic [3:0][31:0] v;
    for (int i = 0; i < 4; i++) v[i] = $urandom;
    return v;
  endfunction

  // One vector: accept at cycle 0, check MAX/START timing, done after `delay` WAIT cycles, retire after `bp`.
  task automatic run_txn(input logic [3:0][31:0] x, input int delay, input bit stray, input int bp);
    logic [3:0][31:0] outs;
    check_val("idle_in_ready", bus_s.in_ready, 1'b1);
    in_x = x; in_valid = 1'b1; sm_done = stray;
    tick();
    in_valid = 1'b0; in_x = rand_vec();
    for (int c = 1; c <= 3; c++) begin
      check_val("max_busy", bus_s.busy, 1'b1);
      check_val("max_in_ready", bus_s.in_ready, 1'b0);
      check_val("max_enable", bus_s.sm_enable, 1'b0);
      check_val("max_res_valid", bus_s.res_valid, 1'b0);
      tick();
    end
    check_val("start_enable", bus_s.sm_enable, 1'b1);
    check_val("start_max_signed", bus_s.sm_max, ref_max(x, 1'b1));
    check_val("start_max_unsigned", bus_u.sm_max, ref_max(x, 1'b0));
    for (int i = 0; i < 4; i++) check_val("start_sm_in", dut_sm_in[i], x[i]);
    tick();
    sm_done = 1'b0;
    for (int c = 0; c < delay; c++) begin
      check_val("wait_enable", bus_s.sm_enable, 1'b0);
      check_val("wait_res_valid", bus_s.res_valid, 1'b0);
      tick();
    end
    outs = rand_vec(); sm_out = outs; sm_done = 1'b1;
    check_val("done_cycle_res_valid", bus_s.res_valid, 1'b0);
    tick();
    sm_done = 1'b0; sm_out = ~outs;
    check_val("res_valid_s", bus_s.res_valid, 1'b1);
    check_val("res_valid_u", bus_u.res_valid, 1'b1);
    check_val("res_error", bus_s.res_error, 1'b0);
    for (int i = 0; i < 4; i++) check_val("res_y", dut_res_y[i], outs[i]);
    res_ready = 1'b0;
    for (int c = 0; c < bp; c++) begin
      tick();
      check_val("bp_res_valid", bus_s.res_valid, 1'b1);
      check_val("bp_in_ready", bus_s.in_ready, 1'b0);
      for (int i = 0; i < 4; i++) check_val("bp_res_y", dut_res_y[i], outs[i]);
    end
    res_ready = 1'b1; in_valid = 1'b1;
    check_val("retire_in_ready", bus_s.in_ready, 1'b0);
    tick();
    res_ready = 1'b0; in_valid = 1'b0;
    check_val("post_res_valid", bus_s.res_valid, 1'b0);
    check_val("post_in_ready", bus_s.in_ready, 1'b1);
    check_val("post_busy", bus_s.busy, 1'b0);
    check_val("post_max_held", bus_s.sm_max, ref_max(x, 1'b1));
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_in_ready"}, bus_s.in_ready, 1'b1);
    check_val({tag, "_busy"}, bus_s.busy, 1'b0);
    check_val({tag, "_enable"}, bus_s.sm_enable, 1'b0);
    check_val({tag, "_sm_max"}, bus_s.sm_max, 32'h0);
    check_val({tag, "_res_valid"}, bus_s.res_valid, 1'b0);
    check_val({tag, "_res_error"}, bus_s.res_error, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_val({tag, "_sm_in"}, dut_sm_in[i], 32'h0);
      check_val({tag, "_res_y"}, dut_res_y[i], 32'h0);
    end
  endtask

  initial begin
    logic [3:0][31:0] x;
    int busy_cnt;
    reset = 1'b1; in_valid = 1'b0; sm_done = 1'b0; res_ready = 1'b0;
    in_x = '0; sm_out = '0;
    tick();
    check_reset_values("rst");
    tick();
    reset = 1'b0;
    tick();

    x = {32'h00020000, 32'h00030000, 32'hFFFF0000, 32'h00010000};
    run_txn(x, 4, 1'b0, 0);
    x = {4{32'h00050000}};
    run_txn(x, 1, 1'b1, 0);
    x = {32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    run_txn(x, 0, 1'b0, 10);

    for (int t = 0; t < 20; t++) begin
      x = rand_vec();
      if ($urandom_range(0, 3) == 0) x[2] = x[0];
      if ($urandom_range(0, 3) == 0) x[3] = x[1];
      run_txn(x, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset asserted in cycle 6 (WAIT) wipes the transaction.
    x = rand_vec();
    in_x = x; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check_reset_values("midwait");
    tick();
    reset = 1'b0;
    sm_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("late_done_res_valid", bus_s.res_valid, 1'b0);
      check_val("late_done_busy", bus_s.busy, 1'b0);
    end
    sm_done = 1'b0;
    tick();

    // No sm_done at all: watchdog timeout, or an indefinite WAIT without it.
    x = rand_vec();
    in_x = x; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
`ifdef SOFTMAX_SCHED_WATCHDOG_EN
    for (int c = 0; c < 8; c++) begin
      check_val("wd_pending_res_valid", bus_s.res_valid, 1'b0);
      tick();
    end
    check_val("wd_res_valid", bus_s.res_valid, 1'b1);
    check_val("wd_res_error", bus_s.res_error, 1'b1);
    for (int i = 0; i < 4; i++) check_val("wd_res_y", dut_res_y[i], 32'h0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_val("wd_post_in_ready", bus_s.in_ready, 1'b1);
`else
    busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus_s.busy === 1'b1 && bus_s.res_valid === 1'b0) busy_cnt++;
      tick();
    end
    check_val("nowd_busy_cycles", busy_cnt, 32'd100);
    check_val("nowd_res_error", bus_s.res_error, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("nowd_recover_in_ready", bus_s.in_ready, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/softmax_sched.md
# softmax_sched

Sequencing controller for the 4-lane fixed-point softmax datapath. Accepts one 4-element logit vector per transaction over a valid/ready handshake and computes the vector maximum sequentially. It then drives the datapath's inputs, maximum and one-cycle `softmax_enable` pulse, waits for `softmax_output_ready`, and returns the four results over a second valid/ready handshake. One vector is in flight at a time.

## Interface
- `ARITH_TYPE`, 1, 1 = signed two's-complement compare, 0 = unsigned compare
- `DATA_WIDTH`, 32, width of every data word
- `INTEGER`, 16, integer bits (passed through to the datapath, not used internally)
- `FRACTION`, 16, fraction bits (passed through, not used internally)
- `TIMEOUT_CYCLES`, 64, WAIT watchdog limit; used only when the watchdog is compiled in
- `clk` in 1: sole clock
- `reset` in 1: asynchronous, active-high
- `in_valid` in 1: logit vector valid
- `in_ready` out 1: controller can accept a vector
- `in_x1`..`in_x4` in DATA_WIDTH each: logits
- `sm_enable` out 1: start pulse to the datapath
- `sm_in1`..`sm_in4` out DATA_WIDTH each: datapath logits
- `sm_max` out DATA_WIDTH: datapath `max_input`
- `sm_out1`..`sm_out4` in DATA_WIDTH each: datapath results
- `sm_done` in 1: datapath `softmax_output_ready`
- `res_valid` out 1: results valid
- `res_ready` in 1: consumer accepts results
- `res_y1`..`res_y4` out DATA_WIDTH each: latched results
- `res_error` out 1: transaction aborted by the watchdog; qualified by `res_valid`
- `busy` out 1: state is not IDLE

## Operation
- States and transitions:
  - IDLE → MAX on `in_valid && in_ready`.
  - MAX stays 3 cycles, then → START.
  - START stays 1 cycle, then → WAIT.
  - WAIT → DONE on `sm_done`.
  - DONE → IDLE on `res_valid && res_ready`.
- `in_ready` = 1 only in IDLE. Accepted logits are registered into `sm_in1..4` and held unchanged until the next acceptance.
- MAX: the max register is initialised to x1 on acceptance. In MAX cycles 1, 2 and 3 it compares x2, x3 and x4 in turn and replaces the current max when the element is strictly greater. Ties keep the earlier element.
- Comparison is signed when `ARITH_TYPE`=1 and unsigned when `ARITH_TYPE`=0.
- START: `sm_enable` = 1 for exactly this cycle. `sm_max` holds the final max from START until the next acceptance.
- WAIT: `sm_done` is sampled every cycle. When it is seen, `sm_out1..4` are captured into `res_y1..4`.
- `sm_done` outside WAIT, including in the START cycle, is ignored.
- DONE: `res_valid` = 1. `res_y*` and `res_error` are stable until the handshake completes.
- Asserting `reset` in any state forces IDLE immediately. The in-flight vector is discarded and no `res_valid` is produced for it.

## Timing
- Reset values:
  - `in_ready` = 1; `busy` = 0.
  - `sm_enable` = 0; `sm_in*` = 0; `sm_max` = 0.
  - `res_valid` = 0; `res_y*` = 0; `res_error` = 0.
- With acceptance at cycle 0:
  - MAX occupies cycles 1–3.
  - `sm_enable` is high in cycle 4.
  - WAIT starts in cycle 5.
- If `sm_done` is first high in cycle k ≥ 5, `res_valid` rises in cycle k+1.
- When `res_ready` is high, `res_valid` is high for 1 cycle. IDLE, with `in_ready` = 1, follows in the next cycle.
- Accept-to-start latency is fixed at 4 cycles.
- Minimum throughput: one vector per 7 + (datapath latency) cycles.
- A new vector is never accepted in the same cycle that results are retired.

## Configuration
- `SOFTMAX_SCHED_WATCHDOG_EN` defined:
  - A counter cleared on entry to WAIT increments each cycle in WAIT.
  - On reaching `TIMEOUT_CYCLES` without `sm_done`, the state moves to DONE with `res_error` = 1 and `res_y*` = 0.
  - If `sm_done` arrives in the same cycle the limit is reached, `sm_done` wins and `res_error` = 0.
- Macro undefined: no counter is built, `res_error` is tied to 0, and WAIT is held indefinitely.

## Structure
- Shared package `softmax_pkg`:
  - State enum (IDLE, MAX, START, WAIT, DONE), 3 bits.
  - Lane count constant `SM_LANES` = 4.
- One sub-module, `softmax_max_seq`: the iterative max register plus the `ARITH_TYPE`-selected comparator, with `load`/`step` controls and an index input.

## Test plan
- Signed max, Q16.16: logits 0x00010000, 0xFFFF0000, 0x00030000, 0x00020000 → `sm_max` = 0x00030000 at the cycle-4 `sm_enable` pulse. Drive `sm_done` in cycle 9 → `res_valid` in cycle 10 with `res_y*` = the `sm_out*` values captured that cycle.
- `ARITH_TYPE`=0, same logits → `sm_max` = 0xFFFF0000.
- Ties: all logits 0x00050000 → `sm_max` = 0x00050000. Stray `sm_done` pulses in IDLE and START are ignored (no early `res_valid`).
- Backpressure: hold `res_ready` = 0 for 10 cycles → `res_valid`, `res_y*` and `in_ready` = 0 held stable. Raise `res_ready` → IDLE with `in_ready` = 1 in the next cycle.
- Reset mid-WAIT: assert `reset` in cycle 6 → all outputs return to reset values immediately. A later `sm_done` produces no result.
- Watchdog (macro defined, `TIMEOUT_CYCLES` = 8): no `sm_done` → `res_valid` with `res_error` = 1 and `res_y*` = 0, 8 cycles after WAIT entry. Macro undefined: `busy` stays 1 for 100 cycles.
